// File: rtl/gpio_pkg.sv
// gpio_pkg: shared types and constants for the GPIO input conditioning stage
//   gpio_flt_state_t : shared controller state (INIT while the sync pipe fills, then RUN)
//   INIT_CYCLES      : cycles spent in INIT after reset release
//   CNT_WIDTH        : default debounce counter / filter_len width
//   IO_WIDTH         : default pin count, matching the pad stage
package gpio_pkg;
    typedef enum logic {ST_INIT, ST_RUN} gpio_flt_state_t;
    localparam int INIT_CYCLES = 3;
    localparam int CNT_WIDTH   = 16;
    localparam int IO_WIDTH    = 36;
endpackage

// File: rtl/gpio_in_filter_if.sv
// gpio_in_filter_if: bus between the register/IRQ logic (master) and the input filter (slave)
//   pin_in      : raw pad readback, asynchronous to clk
//   filter_len  : debounce length in clk cycles, 0 bypasses the filter
//   filter_en   : per-pin filter enable
//   clr_rise    : per-pin single-cycle clear of rise_sticky
//   clr_fall    : per-pin single-cycle clear of fall_sticky
//   irq_mask    : per-pin interrupt enable
//   synced      : pin value after the two-flop synchroniser
//   filtered    : debounced pin value
//   rise_sticky : latched 0->1 transitions of filtered
//   fall_sticky : latched 1->0 transitions of filtered
//   irq         : registered masked OR of the sticky flags
interface gpio_in_filter_if
    import gpio_pkg::*;
#(
    parameter int IOWidth  = IO_WIDTH,
    parameter int CntWidth = CNT_WIDTH
);
    logic [IOWidth-1:0]  pin_in;
    logic [CntWidth-1:0] filter_len;
    logic [IOWidth-1:0]  filter_en;
    logic [IOWidth-1:0]  clr_rise;
    logic [IOWidth-1:0]  clr_fall;
    logic [IOWidth-1:0]  irq_mask;
    logic [IOWidth-1:0]  synced;
    logic [IOWidth-1:0]  filtered;
    logic [IOWidth-1:0]  rise_sticky;
    logic [IOWidth-1:0]  fall_sticky;
    logic                irq;

    modport master (
        output pin_in, filter_len, filter_en, clr_rise, clr_fall, irq_mask,
        input  synced, filtered, rise_sticky, fall_sticky, irq
    );

    modport slave (
        input  pin_in, filter_len, filter_en, clr_rise, clr_fall, irq_mask,
        output synced, filtered, rise_sticky, fall_sticky, irq
    );
endinterface

// File: rtl/gpio_pin_filter.sv
// gpio_pin_filter: one pin of the input stage -- synchroniser, debounce counter, edge stickies
//   clk, reset   : system clock, asynchronous active-high reset
//   i_run        : shared controller is in RUN (filter and edge detection active)
//   i_init_load  : one-cycle strobe that copies synced into filtered without flagging edges
//   i_len        : debounce length, 0 bypasses
//   i_en         : filter enable for this pin
//   i_pin        : raw pad value
//   i_clr_rise   : clear rise sticky
//   i_clr_fall   : clear fall sticky
//   o_synced     : synchronised pin value
//   o_filtered   : debounced pin value
//   o_rise       : rise sticky flag
//   o_fall       : fall sticky flag
module gpio_pin_filter
    import gpio_pkg::*;
#(
    parameter int CntWidth = CNT_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_run,
    input  logic                i_init_load,
    input  logic [CntWidth-1:0] i_len,
    input  logic                i_en,
    input  logic                i_pin,
    input  logic                i_clr_rise,
    input  logic                i_clr_fall,
    output logic                o_synced,
    output logic                o_filtered,
    output logic                o_rise,
    output logic                o_fall
);
    logic                r_s1;
    logic                r_sync;
    logic                r_filt;
    logic                r_rise;
    logic                r_fall;
    logic [CntWidth-1:0] r_cnt;

    logic                w_bypass;
    logic                w_mismatch;
    logic                w_flip;
    logic                w_filt_next;
    logic [CntWidth:0]   w_cnt_inc;
    logic [CntWidth-1:0] w_cnt_next;

    // The extra top bit of w_cnt_inc lets the >= compare see count+1 without wrapping,
    // so lowering i_len below the running count flips on the next mismatching cycle.
    always_comb begin
        w_bypass    = !i_en || (i_len == '0);
        w_mismatch  = r_sync ^ r_filt;
        w_cnt_inc   = {1'b0, r_cnt} + (CntWidth+1)'(1);
        w_flip      = w_mismatch && (w_bypass || (w_cnt_inc >= {1'b0, i_len}));
        w_filt_next = i_init_load ? r_sync : (i_run ? (r_filt ^ w_flip) : r_filt);
        w_cnt_next  = (!i_run || !w_mismatch || w_flip) ? '0
                    : (w_cnt_inc[CntWidth] ? r_cnt : w_cnt_inc[CntWidth-1:0]);
    end

    // A new edge and a clear in the same cycle leave the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1   <= 1'b0;
            r_sync <= 1'b0;
            r_filt <= 1'b0;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= i_pin;
            r_sync <= r_s1;
            r_filt <= w_filt_next;
            r_cnt  <= w_cnt_next;
            r_rise <= (i_run && w_filt_next && !r_filt) || (r_rise && !i_clr_rise);
            r_fall <= (i_run && !w_filt_next && r_filt) || (r_fall && !i_clr_fall);
        end
    end

    assign o_synced   = r_sync;
    assign o_filtered = r_filt;
    assign o_rise     = r_rise;
    assign o_fall     = r_fall;
endmodule

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: synchronise, debounce and edge-detect the pad readback bus, raise one masked IRQ
//   clk   : system clock
//   reset : asynchronous active-high reset; returns the stage to INIT
//   bus   : slave side of gpio_in_filter_if (pin/filter/clear/mask inputs, status and irq outputs)
module gpio_in_filter
    import gpio_pkg::*;
#(
    parameter int IOWidth  = IO_WIDTH,
    parameter int CntWidth = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    gpio_in_filter_if.slave  bus
);
    gpio_flt_state_t    r_state;
    logic [1:0]         r_init_cnt;
    logic               r_init_load;
    logic               r_run;
    logic               r_irq;

    logic [IOWidth-1:0] w_synced;
    logic [IOWidth-1:0] w_filtered;
    logic [IOWidth-1:0] w_rise;
    logic [IOWidth-1:0] w_fall;

    // INIT waits for the sync pipe to fill; r_init_load is raised one cycle early so the
    // pins load filtered on the last INIT cycle, and RUN begins on the following edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_init_load <= 1'b0;
            r_run       <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_irq <= |((w_rise | w_fall) & bus.irq_mask);
            if (r_state == ST_INIT) begin
                r_init_cnt  <= r_init_cnt + 2'd1;
                r_init_load <= (r_init_cnt == 2'(INIT_CYCLES - 2));
                if (r_init_load) begin
                    r_state <= ST_RUN;
                    r_run   <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < IOWidth; g++) begin : g_pin
        gpio_pin_filter #(.CntWidth(CntWidth)) u_pin (
            .clk         (clk),
            .reset       (reset),
            .i_run       (r_run),
            .i_init_load (r_init_load),
            .i_len       (bus.filter_len),
            .i_en        (bus.filter_en[g]),
            .i_pin       (bus.pin_in[g]),
            .i_clr_rise  (bus.clr_rise[g]),
            .i_clr_fall  (bus.clr_fall[g]),
            .o_synced    (w_synced[g]),
            .o_filtered  (w_filtered[g]),
            .o_rise      (w_rise[g]),
            .o_fall      (w_fall[g])
        );
    end

    assign bus.synced      = w_synced;
    assign bus.filtered    = w_filtered;
    assign bus.rise_sticky = w_rise;
    assign bus.fall_sticky = w_fall;
    assign bus.irq         = r_irq;
endmodule

// File: tb/tb_gpio_in_filter.sv
// tb_gpio_in_filter: directed scenarios plus randomized traffic checked against a cycle model
module tb_gpio_in_filter;
    localparam int W = 36;
    localparam int C = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    gpio_in_filter_if #(.IOWidth(W), .CntWidth(C)) bus ();

    gpio_in_filter #(.IOWidth(W), .CntWidth(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] m_s1, m_sync, m_filt, m_rise, m_fall;
    logic         m_irq;
    int           m_run [W];
    int           m_cyc;
    bit           m_running;

    function automatic logic [W-1:0] rbits();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    // Advance one clock: the model applies the spec rules to the inputs present at the edge.
    task automatic tick();
        logic [W-1:0] os, of, nf;
        @(posedge clk);
        if (reset) begin
            m_s1 = '0; m_sync = '0; m_filt = '0; m_rise = '0; m_fall = '0; m_irq = 1'b0;
            m_cyc = 0; m_running = 1'b0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            os = m_sync;
            of = m_filt;
            m_irq = |((m_rise | m_fall) & bus.irq_mask);
            m_sync = m_s1;
            m_s1 = bus.pin_in;
            if (!m_running) begin
                m_cyc++;
                if (m_cyc == 3) begin
                    m_filt = os;
                    m_running = 1'b1;
                end
            end else begin
                for (int i = 0; i < W; i++) begin
                    nf[i] = of[i];
                    if (!bus.filter_en[i] || bus.filter_len == 0) begin
                        nf[i] = os[i];
                        m_run[i] = 0;
                    end else if (os[i] == of[i]) begin
                        m_run[i] = 0;
                    end else begin
                        m_run[i]++;
                        if (m_run[i] >= int'(bus.filter_len)) begin
                            nf[i] = ~of[i];
                            m_run[i] = 0;
                        end
                    end
                end
                m_rise = (nf & ~of) | (m_rise & ~bus.clr_rise);
                m_fall = (~nf & of) | (m_fall & ~bus.clr_fall);
                m_filt = nf;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        bus.pin_in = 36'h1; bus.filter_len = '0; bus.filter_en = '0;
        bus.clr_rise = '0; bus.clr_fall = '0; bus.irq_mask = '0;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.synced, bus.filtered, bus.rise_sticky, bus.fall_sticky, bus.irq} !== '0) begin
            n_err++;
            $display("FAIL reset_zero: got %h want 0",
                     {bus.synced, bus.filtered, bus.rise_sticky, bus.fall_sticky, bus.irq});
        end
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        n_cmp++;
        if (bus.filtered !== '0) begin
            n_err++; $display("FAIL init_hold: filtered %h want 0", bus.filtered);
        end
        tick();
        n_cmp++;
        if (bus.filtered !== 36'h1) begin
            n_err++; $display("FAIL init_load: filtered %h want 1", bus.filtered);
        end
        tick();
        n_cmp++;
        if (bus.rise_sticky !== '0 || bus.irq !== 1'b0) begin
            n_err++; $display("FAIL init_no_edge: rise %h irq %b want 0 0", bus.rise_sticky, bus.irq);
        end
    endtask

    task automatic test_filter_rise();
        bus.filter_len = 16'd5; bus.filter_en = 36'h8; bus.irq_mask = 36'h8;
        bus.pin_in[3] = 1'b1;
        repeat (6) tick();
        n_cmp++;
        if (bus.filtered[3] !== 1'b0) begin
            n_err++; $display("FAIL rise_early: filtered[3] %b want 0", bus.filtered[3]);
        end
        tick();
        n_cmp++;
        if (bus.filtered[3] !== 1'b1 || bus.rise_sticky !== 36'h8 || bus.irq !== 1'b0) begin
            n_err++;
            $display("FAIL rise_flip: filt3 %b rise %h irq %b want 1 8 0",
                     bus.filtered[3], bus.rise_sticky, bus.irq);
        end
        tick();
        n_cmp++;
        if (bus.irq !== 1'b1) begin
            n_err++; $display("FAIL rise_irq: irq %b want 1", bus.irq);
        end
    endtask

    task automatic test_glitch();
        bus.pin_in[3] = 1'b0;
        repeat (4) tick();
        bus.pin_in[3] = 1'b1;
        repeat (12) begin
            tick();
            n_cmp++;
            if (bus.filtered[3] !== 1'b1 || bus.fall_sticky !== '0) begin
                n_err++;
                $display("FAIL glitch: filt3 %b fall %h want 1 0", bus.filtered[3], bus.fall_sticky);
            end
        end
    endtask

    task automatic test_clr_same_cycle();
        bus.pin_in[3] = 1'b0;
        repeat (7) tick();
        n_cmp++;
        if (bus.fall_sticky[3] !== 1'b1) begin
            n_err++; $display("FAIL fall_set: fall[3] %b want 1", bus.fall_sticky[3]);
        end
        bus.clr_rise = 36'h8; bus.clr_fall = 36'h8;
        tick();
        bus.clr_rise = '0; bus.clr_fall = '0;
        tick();
        n_cmp++;
        if (bus.rise_sticky !== '0 || bus.fall_sticky !== '0 || bus.irq !== 1'b0) begin
            n_err++;
            $display("FAIL clr_both: rise %h fall %h irq %b want 0 0 0",
                     bus.rise_sticky, bus.fall_sticky, bus.irq);
        end
        bus.pin_in[3] = 1'b1;
        repeat (6) tick();
        bus.clr_rise = 36'h8;
        tick();
        n_cmp++;
        if (bus.rise_sticky[3] !== 1'b1 || bus.filtered[3] !== 1'b1) begin
            n_err++;
            $display("FAIL set_wins: rise[3] %b filt3 %b want 1 1", bus.rise_sticky[3], bus.filtered[3]);
        end
        tick();
        bus.clr_rise = '0;
        n_cmp++;
        if (bus.rise_sticky[3] !== 1'b0 || bus.irq !== 1'b1) begin
            n_err++;
            $display("FAIL clr_alone: rise[3] %b irq %b want 0 1", bus.rise_sticky[3], bus.irq);
        end
        tick();
        n_cmp++;
        if (bus.irq !== 1'b0) begin
            n_err++; $display("FAIL irq_drop: irq %b want 0", bus.irq);
        end
    endtask

    task automatic test_len_change();
        bus.filter_len = 16'd100;
        bus.pin_in[3] = 1'b0;
        repeat (52) tick();
        n_cmp++;
        if (bus.filtered[3] !== 1'b1) begin
            n_err++; $display("FAIL len_hold: filt3 %b want 1", bus.filtered[3]);
        end
        bus.filter_len = 16'd2;
        tick();
        n_cmp++;
        if (bus.filtered[3] !== 1'b0 || bus.fall_sticky[3] !== 1'b1) begin
            n_err++;
            $display("FAIL len_shrink: filt3 %b fall[3] %b want 0 1", bus.filtered[3], bus.fall_sticky[3]);
        end
        bus.filter_len = '0;
        bus.pin_in[3] = 1'b1;
        tick(); tick();
        n_cmp++;
        if (bus.filtered[3] !== 1'b0) begin
            n_err++; $display("FAIL bypass_early: filt3 %b want 0", bus.filtered[3]);
        end
        tick();
        n_cmp++;
        if (bus.filtered[3] !== 1'b1) begin
            n_err++; $display("FAIL bypass_latency: filt3 %b want 1", bus.filtered[3]);
        end
    endtask

    task automatic test_reset_mid();
        bus.filter_len = 16'd20;
        bus.pin_in[3] = 1'b0;
        repeat (8) tick();
        #3 reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.synced, bus.filtered, bus.rise_sticky, bus.fall_sticky, bus.irq} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got %h want 0",
                     {bus.synced, bus.filtered, bus.rise_sticky, bus.fall_sticky, bus.irq});
        end
        tick(); tick();
        reset = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (bus.filtered !== 36'h1 || bus.rise_sticky !== '0 || bus.fall_sticky !== '0) begin
            n_err++;
            $display("FAIL reinit: filt %h rise %h fall %h want 1 0 0",
                     bus.filtered, bus.rise_sticky, bus.fall_sticky);
        end
        repeat (4) begin
            tick();
            n_cmp++;
            if ({bus.synced, bus.filtered, bus.rise_sticky, bus.fall_sticky, bus.irq} !==
                {m_sync, m_filt, m_rise, m_fall, m_irq}) begin
                n_err++;
                $display("FAIL reinit_model: got %h want %h",
                         {bus.synced, bus.filtered, bus.rise_sticky, bus.fall_sticky, bus.irq},
                         {m_sync, m_filt, m_rise, m_fall, m_irq});
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            bus.pin_in = bus.pin_in ^ (rbits() & rbits() & rbits());
            bus.clr_rise = rbits() & rbits() & rbits();
            bus.clr_fall = rbits() & rbits() & rbits();
            if (k % 60 == 0) bus.filter_len = 16'($urandom_range(0, 6));
            if (k % 90 == 0) bus.filter_en = rbits();
            if (k % 45 == 0) bus.irq_mask = rbits();
            if (k == 400) #2 reset = 1'b1;
            if (k == 402) reset = 1'b0;
            tick();
            n_cmp++;
            if ({bus.synced, bus.filtered, bus.rise_sticky, bus.fall_sticky, bus.irq} !==
                {m_sync, m_filt, m_rise, m_fall, m_irq}) begin
                n_err++;
                $display("FAIL random@%0d: got %h want %h", k,
                         {bus.synced, bus.filtered, bus.rise_sticky, bus.fall_sticky, bus.irq},
                         {m_sync, m_filt, m_rise, m_fall, m_irq});
            end
        end
    endtask

    initial begin
        test_reset();
        test_filter_rise();
        test_glitch();
        test_clr_same_cycle();
        test_len_change();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
